count_stream_monitor: RTL and testbench

//   Receive-side checker for the free-running count the user project drives onto its GPIO pads.
//   - Samples a BITS-wide count bus every clock.
//   - Locks onto the sequence and flags every sample that is not previous+1 (mod 2^BITS).
//   - Keeps a saturating error tally.

---
 rtl/count_mon_pkg.sv | 27 ++
 rtl/count_mon_sync.sv | 32 +++
 rtl/count_stream_monitor.sv | 146 ++++++++++++++
 tb/tb_count_stream_monitor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// -----------------------------------------------------------------------------
// count_mon_pkg
// Shared definitions for the count stream monitor:
//   - tracker FSM state encoding (IDLE / SEED / TRACK / LOCKED)
//   - saturating increment helper used by the error tally
// No ports (package).
// -----------------------------------------------------------------------------
package count_mon_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [STATE_W-1:0] ST_SEED   = 2'd1;
   localparam logic [STATE_W-1:0] ST_TRACK  = 2'd2;
   localparam logic [STATE_W-1:0] ST_LOCKED = 2'd3;

   // Returns value+1, or max_value once value has reached it.
   // Callers zero-extend their counter to 32 bits and truncate the result.
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] max_value);
      if (value >= max_value)
         return max_value;
      else
         return value + 32'd1;
   endfunction

endpackage

// File: rtl/count_mon_sync.sv
// -----------------------------------------------------------------------------
// count_mon_sync
// BITS-wide two-flop synchronizer for a count bus arriving from an unrelated
// clock domain. Multi-bit integrity relies on the source being Gray coded.
// Ports:
//   clk    in   1     destination clock, rising edge
//   rst_n  in   1     asynchronous, active-low reset
//   d      in   BITS  asynchronous count bus
//   q      out  BITS  synchronized count bus (2 cycles latency)
// -----------------------------------------------------------------------------
module count_mon_sync #(
   parameter int BITS = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [BITS-1:0] d,
   output logic [BITS-1:0] q
);

   logic [BITS-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/count_stream_monitor.sv
// -----------------------------------------------------------------------------
// count_stream_monitor
// Receive-side checker for a free-running count looped back onto the pads.
// Samples cnt_in every clock, locks onto the incrementing sequence, flags each
// sample that is not previous+1 (mod 2^BITS) and keeps a saturating tally.
//
// Build option: define COUNT_MON_SYNC_EN to put a 2-flop synchronizer
// (count_mon_sync) in front of the input register; cnt_in to err_pulse
// latency becomes 4 edges instead of 2.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   en          in   1      monitor enable (level, used unregistered)
//   clr         in   1      synchronous clear of err_count and run tracking
//   cnt_in      in   BITS   count bus from pads
//   locked      out  1      LOCK_RUN consecutive in-sequence samples since (re)seed
//   err_pulse   out  1      one-cycle pulse per out-of-sequence sample
//   err_count   out  ERR_W  saturating mismatch count
//   last_value  out  BITS   most recent sample accepted into the tracker
// -----------------------------------------------------------------------------
module count_stream_monitor
   import count_mon_pkg::*;
#(
   parameter int BITS     = 2,
   parameter int LOCK_RUN = 4,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [BITS-1:0]  cnt_in,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [BITS-1:0]  last_value
);

   localparam int RUN_W = $clog2(LOCK_RUN);
   // Run value that, when matched once more, completes the lock run.
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_RUN - 2);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   logic [STATE_W-1:0] state;
   logic [BITS-1:0]    stage_in;
   logic [BITS-1:0]    smp;
   logic [BITS-1:0]    exp_val;
   logic [RUN_W-1:0]   run;
   logic               match;
   logic               tracking;

`ifdef COUNT_MON_SYNC_EN
   count_mon_sync #(
      .BITS (BITS)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cnt_in),
      .q     (stage_in)
   );
`else
   assign stage_in = cnt_in;
`endif

   // Input register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         smp <= '0;
      else
         smp <= stage_in;
   end

   // exp_val is kept BITS wide, so the all-ones -> 0 wrap compares as a match.
   assign match    = (smp == exp_val);
   assign tracking = (state == ST_TRACK) || (state == ST_LOCKED);

   // Tracker FSM, run counter and error tally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         err_count  <= '0;
         last_value <= '0;
         exp_val    <= '0;
         run        <= '0;
      end else begin
         err_pulse <= 1'b0;

         if (!en) begin
            // Drop out of tracking; tally and last accepted value are kept.
            state  <= ST_IDLE;
            locked <= 1'b0;
            if (clr) begin
               err_count <= '0;
               run       <= '0;
            end
         end else begin
            case (state)
               ST_IDLE: begin
                  locked <= 1'b0;
                  state  <= ST_SEED;
               end
               ST_SEED: begin
                  last_value <= smp;
                  exp_val    <= smp + 1'b1;
                  run        <= '0;
                  state      <= ST_TRACK;
               end
               ST_TRACK, ST_LOCKED: begin
                  // A match advances the expectation; a mismatch reseeds from
                  // the offending sample. Either way the sample is accepted.
                  last_value <= smp;
                  exp_val    <= smp + 1'b1;
                  if (!match) begin
                     err_pulse <= 1'b1;
                     run       <= '0;
                     locked    <= 1'b0;
                     state     <= ST_TRACK;
                  end else if (state == ST_TRACK) begin
                     run <= run + 1'b1;
                     if (run == RUN_LAST) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase

            // clr overrides the tally and lock, but an error pulse still fires.
            if (clr) begin
               err_count <= '0;
               run       <= '0;
               locked    <= 1'b0;
               if (tracking)
                  state <= ST_TRACK;
            end else if (tracking && !match) begin
               err_count <= ERR_W'(sat_inc(32'(err_count), 32'(ERR_MAX)));
            end
         end
      end
   end

endmodule

// File: tb/tb_count_stream_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_stream_monitor
// Directed bench for count_stream_monitor (BITS=2, LOCK_RUN=4, ERR_W=8) plus a
// second instance with ERR_W=2 for the saturation case. The cnt_in to
// err_pulse latency follows COUNT_MON_SYNC_EN.
// -----------------------------------------------------------------------------
module tb_count_stream_monitor;

`ifdef COUNT_MON_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       en     = 1'b0;
   logic       clr    = 1'b0;
   logic [1:0] cnt_in = 2'd0;
   logic       locked;
   logic       err_pulse;
   logic [7:0] err_count;
   logic [1:0] last_value;

   logic       en2    = 1'b0;
   logic       clr2   = 1'b0;
   logic [1:0] cnt2   = 2'd0;
   logic       locked2;
   logic       err_pulse2;
   logic [1:0] err_count2;
   logic [1:0] last_value2;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [1:0] dhist [0:1023];
   int         nd  = 0;
   logic [1:0] cur = 2'd0;
   logic [1:0] x;
   int         e_cnt;

   always #5 clk = ~clk;

   count_stream_monitor #(.BITS(2), .LOCK_RUN(4), .ERR_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .clr        (clr),
      .cnt_in     (cnt_in),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_count  (err_count),
      .last_value (last_value)
   );

   count_stream_monitor #(.BITS(2), .LOCK_RUN(4), .ERR_W(2)) dut_sat (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en2),
      .clr        (clr2),
      .cnt_in     (cnt2),
      .locked     (locked2),
      .err_pulse  (err_pulse2),
      .err_count  (err_count2),
      .last_value (last_value2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Present one value on cnt_in and let one rising edge pass.
   task automatic drive(input logic [1:0] v);
      cnt_in    = v;
      dhist[nd] = v;
      nd++;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_next();
      drive(cur);
      cur = cur + 2'd1;
   endtask

   initial begin
      // Reset state before any clock edge
      #2;
      chk("rst_locked", locked, 0);
      chk("rst_err_pulse", err_pulse, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_last_value", last_value, 0);
      chk("rst_sat_count", err_count2, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Lock + wrap: stream 1,2,3,0 fills the pipeline, then en with 1,2,3,0,1
      cur = 2'd1;
      repeat (4) drive_next();
      en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive_next();
         chk("lock_pending", locked, 0);
         chk("lock_no_err", err_pulse, 0);
      end
      drive_next();
      chk("lock_rise", locked, 1);
      chk("lock_err_count", err_count, 0);
      chk("lock_last_value", last_value, dhist[nd-LAT]);
      drive_next();
      chk("lock_hold", locked, 1);
      chk("lock_hold_no_err", err_pulse, 0);

      // Stall: repeat the previous value once
      drive(cur - 2'd1);
      for (int i = 0; i < LAT - 2; i++) begin
         drive_next();
         chk("stall_pre_pulse", err_pulse, 0);
      end
      drive_next();
      chk("stall_pulse", err_pulse, 1);
      chk("stall_count", err_count, 1);
      chk("stall_unlock", locked, 0);
      drive_next();
      chk("stall_pulse_once", err_pulse, 0);
      chk("stall_relock_1", locked, 0);
      drive_next();
      chk("stall_relock_2", locked, 0);
      drive_next();
      chk("stall_relock", locked, 1);
      chk("stall_count_held", err_count, 1);

      // en drop for one cycle while locked
      en = 1'b0;
      drive_next();
      chk("endrop_unlock", locked, 0);
      chk("endrop_count", err_count, 1);
      chk("endrop_last_value", last_value, dhist[nd-1-LAT]);
      en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive_next();
         chk("endrop_relock_pending", locked, 0);
      end
      drive_next();
      chk("endrop_relock", locked, 1);
      chk("endrop_no_err", err_pulse, 0);
      chk("endrop_count_final", err_count, 1);

      // Asynchronous reset while locked, mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_locked", locked, 0);
      chk("arst_err_pulse", err_pulse, 0);
      chk("arst_err_count", err_count, 0);
      chk("arst_last_value", last_value, 0);
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // clr and mismatch on the same edge with err_count=5
      repeat (4) drive_next();
      en = 1'b1;
      repeat (3) drive_next();
      x = cur - 2'd1;
      for (int j = 0; j <= LAT + 5; j++) begin
         clr = (j == LAT + 4);
         drive(x);
         clr = 1'b0;
         if (j == LAT + 3) begin
            chk("clr_pre_count", err_count, 5);
            chk("clr_pre_pulse", err_pulse, 1);
         end
         if (j == LAT + 4) begin
            chk("clr_count", err_count, 0);
            chk("clr_pulse", err_pulse, 1);
            chk("clr_locked", locked, 0);
         end
         if (j == LAT + 5)
            chk("clr_post_count", err_count, 1);
      end

      // Saturation on the ERR_W=2 instance: cnt held at 0
      en2 = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         e_cnt = i - 2;
         if (e_cnt < 0) e_cnt = 0;
         if (e_cnt > 3) e_cnt = 3;
         chk("sat_count", err_count2, e_cnt);
         chk("sat_pulse", err_pulse2, (i >= 3) ? 1 : 0);
         chk("sat_locked", locked2, 0);
         chk("sat_last_value", last_value2, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
